// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// The optional match counter in the top is enabled with the SEQ_DETECT_CNT_EN macro.
package seq_detect_pkg;

  // Default longest pattern the detector can hold.
  localparam int DEFAULT_MAX_LEN = 8;

  // Width needed to hold a length 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // UNCFG: no valid pattern loaded, stream ignored. ARMED: detector active.
  typedef enum logic {
    UNCFG = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/seq_hist_reg.sv
// Bit history shift register with a saturating fill counter.
// fill counts fresh bits since the last clear, capped at MAX_LEN, so the
// comparator knows when enough bits have arrived to form a full pattern.
// hist_next/fill_next show the values the next accepted bit would produce,
// letting the comparator decide on the same edge that accepts the bit.
module seq_hist_reg
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  localparam int LEN_W  = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic               clear,
  input  logic               drop_fill,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist_next,
  output logic [LEN_W-1:0]   fill_next
);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  // Look-ahead of the history and fill after accepting bit_in.
  always_comb begin
    hist_next = {hist_q[MAX_LEN-2:0], bit_in};
    fill_next = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  end

  // Clear wins over shift; drop_fill restarts the fresh-bit count after a
  // non-overlapping match while still keeping the shifted-in bit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist_next;
      fill_q <= drop_fill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits).
// Optional feature macro: SEQ_DETECT_CNT_EN adds a saturating match_count.
//
// Stream handshake: in_valid qualifies inp_bit for exactly one cycle; there is
// no back-pressure, every cycle with in_valid=1 is one accepted bit, except a
// cycle that also carries cfg_load, where the configuration wins and the bit
// is dropped.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
`ifdef SEQ_DETECT_CNT_EN
  parameter int CNT_W   = 8,
`endif
  localparam int LEN_W  = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               inp_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               seq_seen,
  output logic               armed,
  output logic               cfg_err
`ifdef SEQ_DETECT_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;

  logic               cfg_legal;
  logic               cfg_accept;
  logic               shift;
  logic               match;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;

  // Decode config legality, bit acceptance and the masked pattern compare.
  always_comb begin
    cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    cfg_accept = cfg_load && cfg_legal;
    shift      = (state == ARMED) && in_valid && !cfg_load;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = shift && (fill_next >= len_q) &&
            (((hist_next ^ pattern_q) & len_mask) == '0);
  end

  seq_hist_reg #(
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .shift     (shift),
    .clear     (cfg_accept),
    .drop_fill (match && !overlap_q),
    .bit_in    (inp_bit),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  // Control FSM: config latching and registered pulse/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      seq_seen  <= 1'b0;
      armed     <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      seq_seen <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_load) begin
        if (cfg_legal) begin
          state     <= ARMED;
          armed     <= 1'b1;
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          overlap_q <= cfg_overlap;
        end else begin
          cfg_err <= 1'b1;
        end
      end else begin
        case (state)
          UNCFG:   seq_seen <= 1'b0;
          ARMED:   seq_seen <= match;
          default: seq_seen <= 1'b0;
        endcase
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  // Saturating count of match pulses, restarted by each accepted config.
  always_ff @(posedge clk) begin
    if (reset || cfg_accept) begin
      match_count <= '0;
    end else if (seq_seen && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog with MAX_LEN=8: a reference model pushes the
// expected outputs of every cycle into exp_q; they are popped and compared
// on the falling edge after the DUT has registered them.
module tb_seq_detect_prog;
  import seq_detect_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int W       = 4; // {cnt_clear, armed, seq_seen, cfg_err}

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               inp_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               seq_seen;
  logic               armed;
  logic               cfg_err;
`ifdef SEQ_DETECT_CNT_EN
  logic [7:0]         match_count;
`endif

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .inp_bit     (inp_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .seq_seen    (seq_seen),
    .armed       (armed),
    .cfg_err     (cfg_err)
`ifdef SEQ_DETECT_CNT_EN
    ,
    .match_count (match_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  // reference model
  logic         m_armed = 1'b0;
  logic [7:0]   m_pat   = '0;
  int           m_len   = 0;
  logic         m_ovl   = 1'b0;
  logic         m_bits[$];
  int           m_cnt   = 0;
  logic         m_prev_seq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, predict its outputs, then compare after the edge.
  task automatic cycle(input logic rst, input logic ld, input logic [7:0] pat,
                       input int len, input logic ovl, input logic vld, input logic b);
    logic [W-1:0] e;
    logic         hit;
    reset       = rst;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    in_valid    = vld;
    inp_bit     = b;

    if (rst) begin
      m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      m_bits.delete();
      e = 4'b1000;
    end else if (ld) begin
      if (len >= 1 && len <= MAX_LEN) begin
        m_armed = 1'b1; m_pat = pat; m_len = len; m_ovl = ovl;
        m_bits.delete();
        e = 4'b1100;
      end else begin
        e = {1'b0, m_armed, 1'b0, 1'b1};
      end
    end else if (m_armed && vld) begin
      m_bits.push_back(b);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      hit = 1'b0;
      if (m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
      e = {1'b0, 1'b1, hit, 1'b0};
    end else begin
      e = {1'b0, m_armed, 1'b0, 1'b0};
    end
    exp_q.push_back(e);

    @(posedge clk);
    @(negedge clk);

    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("armed",    32'(armed),    32'(e[2]));
      chk("seq_seen", 32'(seq_seen), 32'(e[1]));
      chk("cfg_err",  32'(cfg_err),  32'(e[0]));
      if (e[3]) m_cnt = 0;
      else if (m_prev_seq && m_cnt < 255) m_cnt++;
      m_prev_seq = e[1];
`ifdef SEQ_DETECT_CNT_EN
      chk("match_count", 32'(match_count), 32'(m_cnt));
`endif
    end
  endtask

  task automatic bit_in(input logic b);
    cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, b);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] pat, input int len, input logic ovl);
    cycle(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; inp_bit = 1'b0;
    @(negedge clk);

    // unconfigured: stream ignored
    do_reset();
    do_reset();
    stream(16'b1011, 4);
    idle();

    // non-overlapping 1011: one hit after the 4th bit
    cfg(8'b0000_1011, 4, 1'b0);
    stream(16'b1011011, 7);
    idle();

    // overlapping, upper pattern bits are junk: hits after 4th and 7th
    cfg(8'b1111_1011, 4, 1'b1);
    stream(16'b1011011, 7);
    idle();

    // in_valid gaps in the middle of the pattern
    cfg(8'b0000_1011, 4, 1'b0);
    bit_in(1'b1); bit_in(1'b0);
    idle(); idle(); idle();
    bit_in(1'b1); bit_in(1'b1);
    idle();

    // illegal lengths rejected, prior config still detects
    cfg(8'b0000_0110, 0, 1'b1);
    cfg(8'b0000_0110, 9, 1'b1);
    stream(16'b1011, 4);
    cfg(8'b0000_0110, 15, 1'b0);
    stream(16'b1011, 4);

    // cfg_load with in_valid: the bit is dropped
    cycle(1'b0, 1'b1, 8'b0000_1011, 4, 1'b0, 1'b1, 1'b1);
    stream(16'b011, 3);
    bit_in(1'b1);
    stream(16'b011, 3);
    idle();

    // len=1 back-to-back hits
    cfg(8'b0000_0001, 1, 1'b1);
    stream(16'b1110, 4);

    // full-length pattern
    cfg(8'b1001_0110, 8, 1'b1);
    stream(16'b1001_0110_1001_0110, 16);

    // reset mid-stream discards history
    cfg(8'b0000_1011, 4, 1'b0);
    stream(16'b101, 3);
    do_reset();
    stream(16'b1, 1);
    cfg(8'b0000_1011, 4, 1'b0);
    stream(16'b1, 1);
    stream(16'b011, 3);

    // random configs and streams
    for (int r = 0; r < 12; r++) begin
      cfg(8'($urandom_range(0, 255)), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 39) == 0)
          cfg(8'($urandom_range(0, 255)), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
        else
          cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
      end
    end

`ifdef SEQ_DETECT_CNT_EN
    // counter saturation
    cfg(8'b0000_0001, 1, 1'b1);
    for (int i = 0; i < 262; i++) bit_in(1'b1);
    idle(); idle();
`endif

    if (exp_q.size() != 0) chk("exp_q_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
